// File: rtl/dpram64_ctrl_pkg.sv
// rtl/dpram64_ctrl_pkg.sv - shared widths, line-index helper and response entry type
package dpram64_ctrl_pkg;
  localparam int AXI_DATA_WIDTH = 512;
  localparam int SIZE           = 65536;
  localparam int ADDR_WIDTH     = $clog2(SIZE);
  localparam int STRB_W         = AXI_DATA_WIDTH / 8;
  localparam int OFF_W          = $clog2(STRB_W);
  localparam int LINE_W         = ADDR_WIDTH - OFF_W;

  // Clears the byte offset so the RAM always sees line-aligned addresses
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'((1 << OFF_W) - 1);

  typedef logic [AXI_DATA_WIDTH-1:0] rsp_entry_t;

  function automatic logic [LINE_W-1:0] line_of(input logic [ADDR_WIDTH-1:0] addr);
    return LINE_W'(addr >> OFF_W);
  endfunction
endpackage

// File: rtl/dpram64_ctrl_if.sv
// rtl/dpram64_ctrl_if.sv - requester-side write, read and response handshakes
interface dpram64_ctrl_if #(
  parameter int REQ_NUM = 2
);
  import dpram64_ctrl_pkg::*;

  logic [REQ_NUM-1:0]                     wr_valid;
  logic [REQ_NUM-1:0]                     wr_ready;
  logic [REQ_NUM-1:0][ADDR_WIDTH-1:0]     wr_addr;
  logic [REQ_NUM-1:0][AXI_DATA_WIDTH-1:0] wr_data;
  logic [REQ_NUM-1:0][STRB_W-1:0]         wr_strb;
  logic [REQ_NUM-1:0]                     rd_valid;
  logic [REQ_NUM-1:0]                     rd_ready;
  logic [REQ_NUM-1:0][ADDR_WIDTH-1:0]     rd_addr;
  logic [REQ_NUM-1:0]                     rsp_valid;
  logic [REQ_NUM-1:0]                     rsp_ready;
  logic [REQ_NUM-1:0][AXI_DATA_WIDTH-1:0] rsp_data;

  modport master (
    output wr_valid, wr_addr, wr_data, wr_strb, rd_valid, rd_addr, rsp_ready,
    input  wr_ready, rd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_strb, rd_valid, rd_addr, rsp_ready,
    output wr_ready, rd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/dpram64_ctrl_rsp_fifo.sv
// rtl/dpram64_ctrl_rsp_fifo.sv - 2-entry response FIFO; an incoming push is visible the same cycle
module dpram64_ctrl_rsp_fifo
  import dpram64_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  rsp_entry_t push_data,
  input  logic       pop,
  output logic       valid,
  output rsp_entry_t data,
  output logic [1:0] cnt
);
  rsp_entry_t mem [2];
  logic       rd_ptr;
  logic       wr_ptr;
  logic       pass;
  logic       do_store;
  logic       do_pop_stored;

  // The RAM word arriving this cycle counts as the head when nothing is stored
  assign valid         = (cnt != 2'd0) || push;
  assign data          = (cnt != 2'd0) ? mem[rd_ptr] : (push ? push_data : '0);
  assign pass          = (cnt == 2'd0) && push && pop;
  assign do_store      = push && !pass;
  assign do_pop_stored = pop && (cnt != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_store)      wr_ptr <= ~wr_ptr;
      if (do_pop_stored) rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, do_store} - {1'b0, do_pop_stored};
    end
  end

  always_ff @(posedge clk) begin
    if (do_store) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/dpram64_ctrl.sv
// rtl/dpram64_ctrl.sv - round-robin scheduler for the dpram64 write and read ports
// Optional: DPRAM64_CTRL_RAW_BYPASS_EN grants same-line read/write together and forwards the write.
module dpram64_ctrl
  import dpram64_ctrl_pkg::*;
#(
  parameter int REQ_NUM = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  dpram64_ctrl_if.slave             bus,
  output logic [STRB_W-1:0]         ram_we,
  output logic [AXI_DATA_WIDTH-1:0] ram_din,
  output logic [ADDR_WIDTH-1:0]     ram_waddr,
  output logic [ADDR_WIDTH-1:0]     ram_raddr,
  input  logic [AXI_DATA_WIDTH-1:0] ram_dout
);
  localparam int IDX_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

  // Nearest requester at or after ptr wins; MSB of the result flags any request
  function automatic logic [IDX_W:0] rr_pick(input logic [REQ_NUM-1:0] req,
                                             input logic [IDX_W-1:0]   ptr);
    logic [IDX_W:0] pick;
    int c;
    pick = '0;
    for (int k = REQ_NUM - 1; k >= 0; k--) begin
      c = (int'(ptr) + k) % REQ_NUM;
      if (req[IDX_W'(c)]) pick = {1'b1, IDX_W'(c)};
    end
    return pick;
  endfunction

  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx);
    return (int'(idx) == REQ_NUM - 1) ? '0 : idx + 1'b1;
  endfunction

  logic [IDX_W-1:0]                       wr_ptr, rd_ptr, wr_idx, rd_idx;
  logic                                   wr_any, rd_any, same_line, hazard;
  logic                                   wr_gnt, rd_gnt;
  logic [REQ_NUM-1:0]                     rd_elig, inflight, rsp_valid;
  logic [REQ_NUM-1:0][1:0]                fifo_cnt;
  logic [REQ_NUM-1:0][AXI_DATA_WIDTH-1:0] rsp_data;
  rsp_entry_t                             push_data;

  // Outstanding = stored entries plus the read whose data lands this cycle
  always_comb begin
    rd_elig = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      rd_elig[i] = bus.rd_valid[i] && ((fifo_cnt[i] + {1'b0, inflight[i]}) < 2'd2);
    end
  end

  assign {wr_any, wr_idx} = rr_pick(bus.wr_valid, wr_ptr);
  assign {rd_any, rd_idx} = rr_pick(rd_elig, rd_ptr);
  assign same_line = line_of(bus.wr_addr[wr_idx]) == line_of(bus.rd_addr[rd_idx]);

`ifdef DPRAM64_CTRL_RAW_BYPASS_EN
  assign hazard = 1'b0;
`else
  assign hazard = wr_any && rd_any && same_line;
`endif

  assign wr_gnt = rst_n && wr_any;
  assign rd_gnt = rst_n && rd_any && !hazard;

  assign bus.wr_ready = wr_gnt ? (REQ_NUM'(1) << wr_idx) : '0;
  assign bus.rd_ready = rd_gnt ? (REQ_NUM'(1) << rd_idx) : '0;
  assign ram_we       = wr_gnt ? bus.wr_strb[wr_idx] : '0;
  assign ram_din      = wr_gnt ? bus.wr_data[wr_idx] : '0;
  assign ram_waddr    = wr_gnt ? (bus.wr_addr[wr_idx] & LINE_MASK) : '0;
  assign ram_raddr    = rd_gnt ? (bus.rd_addr[rd_idx] & LINE_MASK) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      inflight <= '0;
    end else begin
      if (wr_gnt) wr_ptr <= rr_next(wr_idx);
      if (rd_gnt) rd_ptr <= rr_next(rd_idx);
      inflight <= bus.rd_ready;
    end
  end

`ifdef DPRAM64_CTRL_RAW_BYPASS_EN
  logic                      byp_valid;
  logic [AXI_DATA_WIDTH-1:0] byp_data;
  logic [STRB_W-1:0]         byp_strb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp_valid <= 1'b0;
      byp_data  <= '0;
      byp_strb  <= '0;
    end else begin
      byp_valid <= wr_gnt && rd_gnt && same_line;
      byp_data  <= ram_din;
      byp_strb  <= ram_we;
    end
  end

  // The RAM returns the pre-write line, so overlay the bytes written alongside the read
  always_comb begin
    push_data = ram_dout;
    if (byp_valid) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (byp_strb[b]) push_data[b*8 +: 8] = byp_data[b*8 +: 8];
      end
    end
  end
`else
  assign push_data = ram_dout;
`endif

  for (genvar i = 0; i < REQ_NUM; i++) begin : g_fifo
    dpram64_ctrl_rsp_fifo u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (inflight[i]),
      .push_data (push_data),
      .pop       (bus.rsp_ready[i]),
      .valid     (rsp_valid[i]),
      .data      (rsp_data[i]),
      .cnt       (fifo_cnt[i])
    );
  end

  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = rsp_data;
endmodule

// File: tb/tb_dpram64_ctrl.sv
// tb/tb_dpram64_ctrl.sv - directed and randomized bench for dpram64_ctrl against a line-level model
module tb_dpram64_ctrl;
  localparam int N = 2;
`ifdef DPRAM64_CTRL_RAW_BYPASS_EN
  localparam bit STALL = 1'b0;
`else
  localparam bit STALL = 1'b1;
`endif
  typedef logic [511:0] line_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] ram_we;
  line_t       ram_din;
  line_t       ram_dout;
  logic [15:0] ram_waddr;
  logic [15:0] ram_raddr;

  dpram64_ctrl_if #(.REQ_NUM(N)) bus ();

  dpram64_ctrl #(.REQ_NUM(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .ram_we    (ram_we),
    .ram_din   (ram_din),
    .ram_waddr (ram_waddr),
    .ram_raddr (ram_raddr),
    .ram_dout  (ram_dout)
  );

  always #5 clk = ~clk;

  // Backing memory: registered read of the pre-write contents, byte-masked write
  line_t ram [1024];
  always @(posedge clk) begin
    ram_dout <= ram[ram_raddr[15:6]];
    for (int b = 0; b < 64; b++)
      if (ram_we[b]) ram[ram_waddr[15:6]][b*8 +: 8] = ram_din[b*8 +: 8];
  end

  line_t        mmem [1024];
  line_t        q [N][$];
  int           wptr_m, rptr_m;
  int           checks, failures;
  logic [N-1:0] g_wr_ready, g_rd_ready, g_rsp_valid;
  line_t        g_rsp_data [N];

  task automatic chk(input string name, input line_t act, input line_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic line_t rnd_line();
    line_t d;
    for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic idle_inputs();
    bus.wr_valid  = '0;
    bus.rd_valid  = '0;
    bus.rsp_ready = '1;
  endtask

  // One cycle: compare at negedge+1, advance the model, return at posedge+1
  task automatic step();
    int    wg, rg, c;
    line_t e;
    @(negedge clk);
    #1;
    g_wr_ready  = bus.wr_ready;
    g_rd_ready  = bus.rd_ready;
    g_rsp_valid = bus.rsp_valid;
    for (int i = 0; i < N; i++) g_rsp_data[i] = bus.rsp_data[i];
    if (!rst_n) begin
      chk("rst_wr_ready", bus.wr_ready, 0);
      chk("rst_rd_ready", bus.rd_ready, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      for (int i = 0; i < N; i++) chk($sformatf("rst_rsp_data%0d", i), bus.rsp_data[i], 0);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_ram_din", ram_din, 0);
      chk("rst_ram_waddr", ram_waddr, 0);
      chk("rst_ram_raddr", ram_raddr, 0);
      for (int i = 0; i < N; i++) q[i].delete();
      wptr_m = 0;
      rptr_m = 0;
    end else begin
      wg = -1;
      rg = -1;
      for (int k = 0; k < N; k++) begin
        c = (wptr_m + k) % N;
        if (wg < 0 && bus.wr_valid[c]) wg = c;
        c = (rptr_m + k) % N;
        if (rg < 0 && bus.rd_valid[c] && q[c].size() < 2) rg = c;
      end
      if (STALL && wg >= 0 && rg >= 0 && bus.wr_addr[wg][15:6] == bus.rd_addr[rg][15:6]) rg = -1;
      if (wg >= 0) begin
        chk("wr_ready", bus.wr_ready, 1 << wg);
        chk("ram_we", ram_we, bus.wr_strb[wg]);
        chk("ram_din", ram_din, bus.wr_data[wg]);
        chk("ram_waddr", ram_waddr, {bus.wr_addr[wg][15:6], 6'd0});
      end else begin
        chk("wr_ready_idle", bus.wr_ready, 0);
        chk("ram_we_idle", ram_we, 0);
      end
      if (rg >= 0) begin
        chk("rd_ready", bus.rd_ready, 1 << rg);
        chk("ram_raddr", ram_raddr, {bus.rd_addr[rg][15:6], 6'd0});
      end else begin
        chk("rd_ready_idle", bus.rd_ready, 0);
      end
      for (int i = 0; i < N; i++) begin
        chk($sformatf("rsp_valid%0d", i), bus.rsp_valid[i], q[i].size() > 0);
        if (q[i].size() > 0) chk($sformatf("rsp_data%0d", i), bus.rsp_data[i], q[i][0]);
      end
      for (int i = 0; i < N; i++)
        if (q[i].size() > 0 && bus.rsp_ready[i]) void'(q[i].pop_front());
      if (wg >= 0) begin
        e = mmem[bus.wr_addr[wg][15:6]];
        for (int b = 0; b < 64; b++)
          if (bus.wr_strb[wg][b]) e[b*8 +: 8] = bus.wr_data[wg][b*8 +: 8];
        mmem[bus.wr_addr[wg][15:6]] = e;
        wptr_m = (wg + 1) % N;
      end
      if (rg >= 0) begin
        q[rg].push_back(mmem[bus.rd_addr[rg][15:6]]);
        rptr_m = (rg + 1) % N;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    line_t exp_line;
    int    acc, stalls, got;
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 1024; i++) begin
      ram[i]  = '0;
      mmem[i] = '0;
    end
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.wr_strb = '0;
    bus.rd_addr = '0;
    idle_inputs();
    bus.rsp_ready = '0;
    wptr_m = 0;
    rptr_m = 0;
    step();
    step();
    rst_n = 1'b1;

    // Round robin between two readers of distinct lines
    bus.rd_valid   = 2'b11;
    bus.rd_addr[0] = 16'h0200;
    bus.rd_addr[1] = 16'h0240;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("rr_grant%0d", k), g_rd_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
    end
    idle_inputs();
    step();
    step();

    // Single write, then read back one cycle later
    bus.wr_valid   = 2'b01;
    bus.wr_addr[0] = 16'h0040;
    bus.wr_data[0] = {64{8'hA5}};
    bus.wr_strb[0] = '1;
    step();
    chk("wr_grant", g_wr_ready, 2'b01);
    idle_inputs();
    bus.rd_valid   = 2'b01;
    bus.rd_addr[0] = 16'h0040;
    step();
    chk("rd_grant", g_rd_ready, 2'b01);
    idle_inputs();
    step();
    chk("rd_lat_valid", g_rsp_valid[0], 1);
    chk("rd_data", g_rsp_data[0], {64{8'hA5}});

    // Partial strobe over a line of 0x11 bytes; read with nonzero offset bits
    bus.wr_valid   = 2'b01;
    bus.wr_addr[0] = 16'h0100;
    bus.wr_data[0] = {64{8'h11}};
    bus.wr_strb[0] = '1;
    step();
    bus.wr_data[0] = {64{8'h22}};
    bus.wr_strb[0] = 64'hF0;
    step();
    idle_inputs();
    bus.rd_valid   = 2'b01;
    bus.rd_addr[0] = 16'h0107;
    step();
    idle_inputs();
    step();
    exp_line        = {64{8'h11}};
    exp_line[63:32] = {4{8'h22}};
    chk("partial_strb", g_rsp_data[0], exp_line);

    // Backpressure: two reads accepted, then blocked until popped in order
    bus.rsp_ready = '0;
    bus.rd_valid  = 2'b01;
    acc = 0;
    for (int k = 0; k < 4; k++) begin
      bus.rd_addr[0] = (acc == 0) ? 16'h0040 : (acc == 1) ? 16'h0100 : 16'h0200;
      step();
      if (g_rd_ready[0]) acc++;
    end
    chk("bp_accepted", acc, 2);
    chk("bp_blocked", g_rd_ready[0], 0);
    bus.rd_valid  = '0;
    bus.rsp_ready = 2'b01;
    step();
    chk("bp_first_valid", g_rsp_valid[0], 1);
    chk("bp_first", g_rsp_data[0], {64{8'hA5}});
    step();
    chk("bp_second", g_rsp_data[0], exp_line);
    bus.rd_valid   = 2'b01;
    bus.rd_addr[0] = 16'h0200;
    step();
    chk("bp_resume", g_rd_ready[0], 1);
    idle_inputs();
    step();
    step();

    // Same-line write and read in one cycle
    bus.wr_valid   = 2'b01;
    bus.wr_addr[0] = 16'h0080;
    bus.wr_data[0] = 512'h5A;
    bus.wr_strb[0] = 64'h1;
    bus.rd_valid   = 2'b10;
    bus.rd_addr[1] = 16'h0080;
    stalls = 0;
    got    = 0;
    for (int k = 0; k < 4 && got == 0; k++) begin
      step();
      bus.wr_valid = '0;
      if (g_rd_ready[1]) got = 1;
      else stalls++;
    end
    chk("hz_granted", got, 1);
    chk("hz_stall", stalls, STALL ? 1 : 0);
    bus.rd_valid = '0;
    step();
    chk("hz_rsp_valid", g_rsp_valid[1], 1);
    chk("hz_rsp_data", g_rsp_data[1], 512'h5A);
    step();

    // Reset while a read is in flight
    bus.rd_valid   = 2'b01;
    bus.rd_addr[0] = 16'h0040;
    step();
    chk("rst_rd_grant", g_rd_ready[0], 1);
    idle_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("rst_no_rsp", g_rsp_valid, 0);
    bus.wr_valid   = 2'b11;
    bus.wr_addr[0] = 16'h0400;
    bus.wr_addr[1] = 16'h0440;
    bus.wr_strb    = '0;
    bus.rd_valid   = 2'b11;
    bus.rd_addr[0] = 16'h0800;
    bus.rd_addr[1] = 16'h0840;
    step();
    chk("rst_wptr", g_wr_ready, 2'b01);
    chk("rst_rptr", g_rd_ready, 2'b01);
    idle_inputs();
    step();

    // Randomized traffic over a few lines so hazards and backpressure are frequent
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      for (int i = 0; i < N; i++) begin
        bus.wr_valid[i]  = $urandom_range(0, 1) == 1;
        bus.wr_addr[i]   = 16'(($urandom_range(0, 7) << 6) | $urandom_range(0, 63));
        bus.wr_data[i]   = rnd_line();
        case ($urandom_range(0, 3))
          0:       bus.wr_strb[i] = '1;
          1:       bus.wr_strb[i] = '0;
          default: bus.wr_strb[i] = {$urandom, $urandom};
        endcase
        bus.rd_valid[i]  = $urandom_range(0, 1) == 1;
        bus.rd_addr[i]   = 16'(($urandom_range(0, 7) << 6) | $urandom_range(0, 63));
        bus.rsp_ready[i] = $urandom_range(0, 3) != 0;
      end
      step();
    end
    rst_n = 1'b1;
    idle_inputs();
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
